usb_line_replay: RTL and testbench

- Synthesizable replay engine that streams recorded USB line-state samples (D+/D−) out of a word stream, paced by a fractional-rate NCO on a single clock.
- Generalises file-driven line stimulus into a reusable block, used by sim benches and on-FPGA self-test to drive the USB PHY pads or the core's sampled inputs.
- Adds configurable word width, packed multi-sample words, programmable sample rate, end-of-stream handling, an idle line state and underrun accounting.

---
 rtl/usb_line_replay_if.sv | 12 +
 rtl/usb_line_replay.sv | 170 +++++++++++++++++
 tb/tb_usb_line_replay.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_line_replay_if.sv
// Word-stream handshake carrying packed D+/D- line samples into usb_line_replay.
interface usb_line_replay_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;

  modport master (output in_data, output in_last, output in_valid, input in_ready);
  modport slave  (input in_data, input in_last, input in_valid, output in_ready);
endinterface

// File: rtl/usb_line_replay.sv
// Replays recorded USB D+/D- line samples from a word stream, paced by a
// fractional NCO; idles the line between streams and counts underrun ticks.
module usb_line_replay #(
  parameter int DW      = 8,
  parameter int PACK    = 1,
  parameter int PHASE_W = 16,
  parameter bit IDLE_DP = 1'b1,
  parameter bit IDLE_DN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_en,
  input  logic [PHASE_W-1:0] cfg_step,
  usb_line_replay_if.slave   in_if,
  output logic               out_dp,
  output logic               out_dn,
  output logic               out_active,
  output logic               stat_done,
  output logic [15:0]        stat_underrun
);

  localparam int SPW   = (PACK != 0) ? DW / 2 : 1;
  localparam int CNT_W = (SPW > 1) ? $clog2(SPW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [DW-1:0]      buf_q, buf_d;
  logic               buf_last_q, buf_last_d;
  logic               buf_full_q, buf_full_d;
  logic [DW-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]   sr_cnt_q, sr_cnt_d;
  logic               sr_last_q, sr_last_d;
  logic               fin_q, fin_d;
  logic               seen_q, seen_d;
  logic               dp_q, dp_d;
  logic               dn_q, dn_d;
  logic               act_q, act_d;
  logic [15:0]        urun_q, urun_d;

  logic [PHASE_W:0]   sum;
  logic               tick;
  logic               accept;

  assign in_if.in_ready = (state_q == RUN) && !buf_full_q;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign sum            = {1'b0, acc_q} + {1'b0, cfg_step};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    buf_last_d = buf_last_q;
    buf_full_d = buf_full_q;
    sr_d       = sr_q;
    sr_cnt_d   = sr_cnt_q;
    sr_last_d  = sr_last_q;
    fin_d      = fin_q;
    seen_d     = seen_q;
    dp_d       = dp_q;
    dn_d       = dn_q;
    act_d      = act_q;
    urun_d     = urun_q;
    tick       = 1'b0;

    case (state_q)
      IDLE: begin
        acc_d  = '0;
        seen_d = 1'b0;
        fin_d  = 1'b0;
        if (cfg_en) state_d = RUN;
      end
      RUN: begin
        if (cfg_en) begin
          acc_d = sum[PHASE_W-1:0];
          tick  = sum[PHASE_W];
        end
        if (tick) begin
          if (sr_cnt_q != '0) begin
            dp_d     = sr_q[1];
            dn_d     = sr_q[0];
            sr_d     = sr_q >> 2;
            sr_cnt_d = sr_cnt_q - 1'b1;
            act_d    = 1'b1;
            seen_d   = 1'b1;
            fin_d    = (sr_cnt_q == CNT_W'(1)) && sr_last_q;
          end else if (buf_full_q) begin
            dp_d       = buf_q[1];
            dn_d       = buf_q[0];
            sr_d       = buf_q >> 2;
            sr_cnt_d   = CNT_W'(SPW - 1);
            sr_last_d  = buf_last_q;
            buf_full_d = 1'b0;
            act_d      = 1'b1;
            seen_d     = 1'b1;
            fin_d      = (SPW == 1) && buf_last_q;
          end else begin
            // Last sample has now been held a full tick: release the line.
            dp_d  = IDLE_DP;
            dn_d  = IDLE_DN;
            act_d = 1'b0;
            if (fin_q) begin
              state_d = DONE;
            end else if (seen_q && urun_q != 16'hFFFF) begin
              urun_d = urun_q + 16'd1;
            end
          end
        end
        // Applied after consumption so a same-cycle refill keeps the buffer full.
        if (accept) begin
          buf_d      = in_if.in_data;
          buf_last_d = in_if.in_last;
          buf_full_d = 1'b1;
        end
      end
      DONE: begin
        dp_d  = IDLE_DP;
        dn_d  = IDLE_DN;
        act_d = 1'b0;
        if (!cfg_en) begin
          state_d = IDLE;
          urun_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      buf_full_q <= 1'b0;
      sr_q       <= '0;
      sr_cnt_q   <= '0;
      sr_last_q  <= 1'b0;
      fin_q      <= 1'b0;
      seen_q     <= 1'b0;
      dp_q       <= IDLE_DP;
      dn_q       <= IDLE_DN;
      act_q      <= 1'b0;
      urun_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      buf_q      <= buf_d;
      buf_last_q <= buf_last_d;
      buf_full_q <= buf_full_d;
      sr_q       <= sr_d;
      sr_cnt_q   <= sr_cnt_d;
      sr_last_q  <= sr_last_d;
      fin_q      <= fin_d;
      seen_q     <= seen_d;
      dp_q       <= dp_d;
      dn_q       <= dn_d;
      act_q      <= act_d;
      urun_q     <= urun_d;
    end
  end

  assign out_dp        = dp_q;
  assign out_dn        = dn_q;
  assign out_active    = act_q;
  assign stat_done     = (state_q == DONE);
  assign stat_underrun = urun_q;

endmodule

// File: tb/tb_usb_line_replay.sv
// Directed bench for usb_line_replay: a packed (PACK=1) and an unpacked (PACK=0)
// instance, cycle-exact expected traces sampled on the falling edge.
module tb_usb_line_replay;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [15:0] step_a, step_b;
  logic        dp_a, dn_a, act_a, done_a;
  logic        dp_b, dn_b, act_b, done_b;
  logic [15:0] ur_a, ur_b;

  int errors = 0;
  int checks = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic       fire_a, fire_b;

  always #5 clk = ~clk;

  usb_line_replay_if #(.DW(8)) a_if ();
  usb_line_replay_if #(.DW(8)) b_if ();

  usb_line_replay #(.DW(8), .PACK(1), .PHASE_W(16), .IDLE_DP(1'b1), .IDLE_DN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .cfg_en(en_a), .cfg_step(step_a), .in_if(a_if.slave),
    .out_dp(dp_a), .out_dn(dn_a), .out_active(act_a), .stat_done(done_a),
    .stat_underrun(ur_a));

  usb_line_replay #(.DW(8), .PACK(0), .PHASE_W(16), .IDLE_DP(1'b1), .IDLE_DN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cfg_en(en_b), .cfg_step(step_b), .in_if(b_if.slave),
    .out_dp(dp_b), .out_dn(dn_b), .out_active(act_b), .stat_done(done_b),
    .stat_underrun(ur_b));

  // Present queue heads; a word counts as taken if ready was high at this negedge.
  task automatic drive();
    a_if.in_valid = (qa.size() > 0);
    a_if.in_data  = a_if.in_valid ? qa[0][7:0] : 8'h00;
    a_if.in_last  = a_if.in_valid ? qa[0][8]   : 1'b0;
    b_if.in_valid = (qb.size() > 0);
    b_if.in_data  = b_if.in_valid ? qb[0][7:0] : 8'h00;
    b_if.in_last  = b_if.in_valid ? qb[0][8]   : 1'b0;
    fire_a = a_if.in_valid && a_if.in_ready;
    fire_b = b_if.in_valid && b_if.in_ready;
  endtask

  task automatic cyc();
    logic [8:0] dummy;
    @(negedge clk);
    if (fire_a) dummy = qa.pop_front();
    if (fire_b) dummy = qb.pop_front();
    drive();
  endtask

  task automatic reset_dut();
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    step_a = 16'h0; step_b = 16'h0;
    qa.delete(); qb.delete();
    fire_a = 1'b0; fire_b = 1'b0;
    drive();
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({dp_a, dn_a, act_a, done_a, a_if.in_ready} !== 5'b10000) begin
      errors++; $display("FAIL reset_a outs got=%b exp=10000", {dp_a, dn_a, act_a, done_a, a_if.in_ready});
    end
    checks++;
    if (ur_a !== 16'h0) begin errors++; $display("FAIL reset_a underrun got=%h exp=0000", ur_a); end
    checks++;
    if ({dp_b, dn_b, act_b, done_b, b_if.in_ready} !== 5'b10000) begin
      errors++; $display("FAIL reset_b outs got=%b exp=10000", {dp_b, dn_b, act_b, done_b, b_if.in_ready});
    end
  endtask

  // {done,active,dp,dn}; idle line is dp=1 dn=0.
  task automatic test_packed_single();
    logic [7:0] w;
    logic [3:0] exp, got;
    reset_dut();
    w = 8'hE4;
    en_a = 1'b1; step_a = 16'h4000;
    qa.push_back({1'b1, w});
    drive();
    for (int k = 1; k <= 22; k++) begin
      cyc();
      if (k < 5)       exp = 4'b0010;
      else if (k < 21) exp = {2'b01, 2'(w >> (2 * ((k - 5) / 4)))};
      else             exp = 4'b1010;
      got = {done_a, act_a, dp_a, dn_a};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL packed_trace k=%0d got=%b exp=%b", k, got, exp); end
      if (k == 2) begin
        checks++;
        if (a_if.in_ready !== 1'b0) begin errors++; $display("FAIL packed_ready_full got=%b exp=0", a_if.in_ready); end
      end
    end
    checks++;
    if (ur_a !== 16'h0) begin errors++; $display("FAIL packed_underrun got=%h exp=0000", ur_a); end
    en_a = 1'b0;
    cyc();
    checks++;
    if (done_a !== 1'b0) begin errors++; $display("FAIL packed_done_clear got=%b exp=0", done_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    logic [3:0] exp, got;
    reset_dut();
    w[0] = 8'h02; w[1] = 8'h01; w[2] = 8'h03;
    en_b = 1'b1; step_b = 16'h8000;
    qb.push_back({1'b0, w[0]});
    qb.push_back({1'b0, w[1]});
    qb.push_back({1'b1, w[2]});
    drive();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k < 3)      exp = 4'b0010;
      else if (k < 9) exp = {2'b01, w[(k - 3) / 2][1:0]};
      else            exp = 4'b1010;
      got = {done_b, act_b, dp_b, dn_b};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_trace k=%0d got=%b exp=%b", k, got, exp); end
      if (k == 2 || k == 4) begin
        checks++;
        if (b_if.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=0", k, b_if.in_ready); end
      end
    end
    checks++;
    if (qb.size() !== 0) begin errors++; $display("FAIL b2b_words_left got=%0d exp=0", qb.size()); end
  endtask

  task automatic test_underrun();
    logic [7:0] w1, w2;
    logic [3:0] exp, got;
    reset_dut();
    w1 = 8'h1B; w2 = 8'hE4;
    en_a = 1'b1; step_a = 16'h4000;
    qa.push_back({1'b0, w1});
    drive();
    for (int k = 1; k <= 46; k++) begin
      cyc();
      if (k < 5)       exp = 4'b0010;
      else if (k < 21) exp = {2'b01, 2'(w1 >> (2 * ((k - 5) / 4)))};
      else if (k < 29) exp = 4'b0010;
      else if (k < 45) exp = {2'b01, 2'(w2 >> (2 * ((k - 29) / 4)))};
      else             exp = 4'b1010;
      got = {done_a, act_a, dp_a, dn_a};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL underrun_trace k=%0d got=%b exp=%b", k, got, exp); end
      if (k == 21 || k == 25 || k == 46) begin
        checks++;
        if (ur_a !== ((k == 21) ? 16'd1 : 16'd2)) begin
          errors++; $display("FAIL underrun_count k=%0d got=%0d exp=%0d", k, ur_a, (k == 21) ? 1 : 2);
        end
      end
      if (k == 24) begin
        qa.push_back({1'b1, w2});
        drive();
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] w;
    logic [3:0] exp, got;
    reset_dut();
    w = 8'hE4;
    en_a = 1'b1; step_a = 16'h4000;
    qa.push_back({1'b1, w});
    drive();
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k < 5)       exp = 4'b0010;
      else if (k < 19) exp = {2'b01, w[1:0]};
      else if (k < 31) exp = {2'b01, 2'(w >> (2 * ((k - 19) / 4 + 1)))};
      else             exp = 4'b1010;
      got = {done_a, act_a, dp_a, dn_a};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL pause_trace k=%0d got=%b exp=%b", k, got, exp); end
      if (k == 6)  en_a = 1'b0;
      if (k == 16) en_a = 1'b1;
    end
    checks++;
    if (ur_a !== 16'h0) begin errors++; $display("FAIL pause_underrun got=%h exp=0000", ur_a); end
  endtask

  task automatic test_midstream_reset();
    reset_dut();
    en_a = 1'b1; step_a = 16'h4000;
    qa.push_back({1'b1, 8'hE4});
    drive();
    for (int k = 1; k <= 10; k++) cyc();
    checks++;
    if (act_a !== 1'b1) begin errors++; $display("FAIL mid_active_before got=%b exp=1", act_a); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({dp_a, dn_a, act_a, done_a, a_if.in_ready, ur_a} !== {5'b10000, 16'h0}) begin
      errors++; $display("FAIL mid_reset_vals got=%b/%h exp=10000/0000", {dp_a, dn_a, act_a, done_a, a_if.in_ready}, ur_a);
    end
    cyc();
    checks++;
    if ({a_if.in_ready, act_a} !== 2'b10) begin
      errors++; $display("FAIL mid_restart_empty got=%b exp=10", {a_if.in_ready, act_a});
    end
    for (int k = 13; k <= 20; k++) cyc();
    checks++;
    if ({act_a, ur_a} !== {1'b0, 16'h0}) begin
      errors++; $display("FAIL mid_no_count got=%b/%h exp=0/0000", act_a, ur_a);
    end
    qa.push_back({1'b1, 8'hE4});
    drive();
    for (int k = 21; k <= 24; k++) cyc();
    checks++;
    if ({act_a, dp_a, dn_a} !== 3'b100) begin
      errors++; $display("FAIL mid_resume got=%b exp=100", {act_a, dp_a, dn_a});
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    en_a = 1'b1; step_a = 16'hFFFF;
    qa.push_back({1'b0, 8'h1B});
    drive();
    for (int k = 1; k <= 66000; k++) begin
      cyc();
      if (k == 3) begin
        checks++;
        if ({act_a, dp_a, dn_a} !== 3'b111) begin errors++; $display("FAIL sat_first got=%b exp=111", {act_a, dp_a, dn_a}); end
      end
      if (k == 1000) begin
        checks++;
        if (ur_a !== 16'd994) begin errors++; $display("FAIL sat_mid got=%0d exp=994", ur_a); end
      end
    end
    checks++;
    if (ur_a !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", ur_a); end
    qa.push_back({1'b1, 8'h00});
    drive();
    for (int k = 66001; k <= 66010; k++) cyc();
    checks++;
    if ({done_a, ur_a} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL sat_done got=%b/%h exp=1/ffff", done_a, ur_a);
    end
    en_a = 1'b0;
    cyc();
    checks++;
    if ({done_a, ur_a} !== {1'b0, 16'h0}) begin
      errors++; $display("FAIL sat_clear got=%b/%h exp=0/0000", done_a, ur_a);
    end
  endtask

  initial begin
    test_reset();
    test_packed_single();
    test_back_to_back();
    test_underrun();
    test_pause();
    test_midstream_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
